ysyx_22040632_ifu: RTL and testbench

//  Instruction fetch unit; supplies the decode stage with {inst, pc} over a valid/ready handshake.

---
 rtl/ysyx_22040632_ifu.sv | 106 ++++++++++
 tb/tb_ysyx_22040632_ifu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one imem request at a time and
// hands {inst, pc} to decode. A redirect invalidates any fetch already in flight.
module ysyx_22040632_ifu #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              drop_q, drop_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   pc_q, pc_d;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        inst_d     = inst_q;
        pc_d       = pc_q;

        case (state_q)
            S_REQ: begin
                // An accepted request that races a redirect is fetched but must be thrown away.
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        inst_d  = imem_resp_data;
                        pc_d    = fetch_pc_q;
                        state_d = S_OUT;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
                drop_d  = 1'b0;
            end
        endcase

        // Redirect overrides whatever PC update the state machine chose above.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            inst_q     <= 32'h0;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
        end
    end

    // Gated by rst_n so neither side sees a valid while reset is held.
    assign imem_req_valid = rst_n && (state_q == S_REQ);
    assign imem_addr      = fetch_pc_q;
    assign inst_valid     = rst_n && (state_q == S_OUT);
    assign inst           = inst_q;
    assign pc             = pc_q;

endmodule

// File: tb/tb_ysyx_22040632_ifu.sv
// Bench for the fetch unit: directed scenarios plus a randomized run scored against
// an instruction-stream model (expected next PC and address-derived memory contents).
module tb_ysyx_22040632_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_22040632_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] memfn(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_err++;
                $display("FAIL reset_valids: req=%b inst=%b expected 0/0", imem_req_valid, inst_valid); end
        end
        rst_n = 1'b1; #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin n_err++;
            $display("FAIL reset_first_req: req=%b addr=%h expected 1/%h", imem_req_valid, imem_addr, RST_PC); end
        n_cmp++; if (inst_valid !== 1'b0 || inst !== 32'h0 || pc !== RST_PC) begin n_err++;
            $display("FAIL reset_out: v=%b inst=%h pc=%h expected 0/0/%h", inst_valid, inst, pc, RST_PC); end
    endtask

    task automatic test_stream();
        logic [63:0] exp;
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = RST_PC + 64'(4 * k);
            imem_req_ready = 1'b1;
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== exp) begin n_err++;
                $display("FAIL stream_req%0d: req=%b addr=%h expected 1/%h", k, imem_req_valid, imem_addr, exp); end
            cyc();
            imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
            n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_err++;
                $display("FAIL stream_wait%0d: req=%b v=%b expected 0/0", k, imem_req_valid, inst_valid); end
            cyc();
            imem_resp_valid = 1'b0;
            n_cmp++; if (inst_valid !== 1'b1 || pc !== exp || inst !== 32'h0000_0013) begin n_err++;
                $display("FAIL stream_out%0d: v=%b pc=%h inst=%h expected 1/%h/00000013", k, inst_valid, pc, inst, exp); end
            cyc();
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_out_stall();
        imem_req_ready = 1'b1; cyc();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093; cyc();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || pc !== 64'h8000_000C
                         || imem_req_valid !== 1'b0) begin n_err++;
                $display("FAIL out_stall%0d: v=%b inst=%h pc=%h req=%b expected 1/00100093/8000000c/0",
                         i, inst_valid, inst, pc, imem_req_valid); end
            cyc();
        end
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0010) begin n_err++;
            $display("FAIL out_release: req=%b addr=%h expected 1/80000010", imem_req_valid, imem_addr); end
    endtask

    task automatic test_req_stall_redirect();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0010) begin n_err++;
                $display("FAIL req_stall%0d: req=%b addr=%h expected 1/80000010", i, imem_req_valid, imem_addr); end
            cyc();
        end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1002; cyc(); redirect_valid = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_1000) begin n_err++;
            $display("FAIL req_redirect: req=%b addr=%h expected 1/80001000", imem_req_valid, imem_addr); end
    endtask

    task automatic test_wait_redirect();
        imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; cyc(); redirect_valid = 1'b0;
        cyc();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; cyc(); imem_resp_valid = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++;
            $display("FAIL wait_stale_out: v=%b inst=%h expected v=0", inst_valid, inst); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_2000) begin n_err++;
            $display("FAIL wait_refetch: req=%b addr=%h expected 1/80002000", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013; cyc(); imem_resp_valid = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || pc !== 64'h8000_2000) begin n_err++;
            $display("FAIL wait_newinst: v=%b inst=%h pc=%h expected 1/00000013/80002000", inst_valid, inst, pc); end
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
    endtask

    task automatic test_wrap();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; cyc(); redirect_valid = 1'b0;
        n_cmp++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++;
            $display("FAIL wrap_align: addr=%h expected fffffffffffffffc", imem_addr); end
        imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678; cyc(); imem_resp_valid = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || pc !== 64'hFFFF_FFFF_FFFF_FFFC || inst !== 32'h1234_5678) begin n_err++;
            $display("FAIL wrap_out: v=%b pc=%h inst=%h expected 1/fffffffffffffffc/12345678", inst_valid, pc, inst); end
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h0) begin n_err++;
            $display("FAIL wrap_next: req=%b addr=%h expected 1/0", imem_req_valid, imem_addr); end
    endtask

    task automatic test_reset_mid();
        imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
        rst_n = 1'b0; #1;
        n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_err++;
            $display("FAIL midrst_valids: req=%b v=%b expected 0/0", imem_req_valid, inst_valid); end
        cyc();
        rst_n = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin n_err++;
            $display("FAIL midrst_restart: req=%b addr=%h expected 1/%h", imem_req_valid, imem_addr, RST_PC); end
        cyc(); imem_resp_valid = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== RST_PC) begin n_err++;
            $display("FAIL midrst_late_resp: req=%b v=%b addr=%h expected 1/0/%h",
                     imem_req_valid, inst_valid, imem_addr, RST_PC); end
        imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013; cyc(); imem_resp_valid = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || pc !== RST_PC || inst !== 32'h0000_0013) begin n_err++;
            $display("FAIL midrst_fetch: v=%b pc=%h inst=%h expected 1/%h/00000013", inst_valid, pc, inst, RST_PC); end
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
    endtask

    // Model: decode sees consecutive PCs from RESET_PC, restarting at each redirect target;
    // each delivered word is whatever memory holds at that PC.
    task automatic test_random();
        logic [63:0] exp_pc, paddr, prev_addr;
        logic [63:0] prev_pc;
        logic [31:0] prev_inst;
        logic        pend, prev_req, prev_rdy, prev_iv, prev_ir, prev_redir;
        int          cnt, xfers;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        cyc(); rst_n = 1'b1; #1;
        exp_pc = RST_PC; pend = 1'b0; cnt = 0; xfers = 0; paddr = '0;
        prev_req = 1'b0; prev_rdy = 1'b0; prev_iv = 1'b0; prev_ir = 1'b0; prev_redir = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_inst = '0;
        for (int c = 0; c < 3000; c++) begin
            imem_resp_valid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1; imem_resp_data = memfn(paddr); pend = 1'b0;
                end else cnt--;
            end
            imem_req_ready = ($urandom % 3) != 0;
            inst_ready     = ($urandom % 4) != 0;
            redirect_valid = !prev_redir && (($urandom % 12) == 0);
            redirect_pc    = (($urandom % 8) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16))
                                                   : {32'($urandom), 32'($urandom)};
            if (imem_req_valid) begin
                n_cmp++; if (pend || imem_addr[1:0] !== 2'b00) begin n_err++;
                    $display("FAIL rnd_req_legal c=%0d: pend=%b addr=%h expected no outstanding, aligned",
                             c, pend, imem_addr); end
            end
            if (prev_req && !prev_rdy && !prev_redir) begin
                n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== prev_addr) begin n_err++;
                    $display("FAIL rnd_req_hold c=%0d: req=%b addr=%h expected 1/%h", c, imem_req_valid, imem_addr, prev_addr); end
            end
            if (prev_iv && !prev_ir && !prev_redir) begin
                n_cmp++; if (inst_valid !== 1'b1 || inst !== prev_inst || pc !== prev_pc) begin n_err++;
                    $display("FAIL rnd_out_hold c=%0d: v=%b inst=%h pc=%h expected 1/%h/%h",
                             c, inst_valid, inst, pc, prev_inst, prev_pc); end
            end
            if (inst_valid && inst_ready) begin
                n_cmp++; if (pc !== exp_pc || inst !== memfn(exp_pc)) begin n_err++;
                    $display("FAIL rnd_xfer c=%0d: pc=%h inst=%h expected %h/%h", c, pc, inst, exp_pc, memfn(exp_pc)); end
                exp_pc = exp_pc + 64'd4;
                xfers++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
            if (imem_req_valid && imem_req_ready) begin
                pend = 1'b1; paddr = imem_addr; cnt = int'($urandom % 3);
            end
            prev_req = imem_req_valid; prev_rdy = imem_req_ready; prev_addr = imem_addr;
            prev_iv = inst_valid; prev_ir = inst_ready; prev_inst = inst; prev_pc = pc;
            prev_redir = redirect_valid;
            cyc();
        end
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        n_cmp++; if (xfers < 100) begin n_err++;
            $display("FAIL rnd_progress: transfers=%0d expected at least 100", xfers); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_out_stall();
        test_req_stall_redirect();
        test_wait_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
